// File: rtl/max6675_responder_pkg.sv
// Shared constants, state encoding and frame packing for the MAX6675 responder.
// The frame is 16 bits, sent MSB first: a dummy 0 bit, then the 12-bit temperature
// code, then the open-thermocouple flag, the device ID bit (0) and a final 0 bit.
package max6675_pkg;

  localparam int FRAME_BITS = 16;
  localparam int TEMP_MSB   = 14;
  localparam int TEMP_LSB   = 3;
  localparam int OPEN_BIT   = 2;

  typedef enum logic [1:0] {
    CONV  = 2'd0,
    READY = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Places the temperature code and the open flag at their frame positions.
  // Every other bit of the frame is zero.
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [11:0] temp_code,
                                                       input logic        tc_open);
    logic [FRAME_BITS-1:0] f;
    f                    = '0;
    f[TEMP_MSB:TEMP_LSB] = temp_code;
    f[OPEN_BIT]          = tc_open;
    return f;
  endfunction

endpackage

// File: rtl/max6675_responder_if.sv
// SPI pin bundle between a MAX6675 reader (master) and the responder (slave).
// The master drives sclk and cs_n; the slave drives so and its pad enable so_oe.
// The bundle carries no flow control; the master owns all of the timing.
interface max6675_responder_if;
  logic sclk;
  logic cs_n;
  logic so;
  logic so_oe;

  modport master (output sclk, output cs_n, input so, input so_oe);
  modport slave  (input sclk, input cs_n, output so, output so_oe);
endinterface

// File: rtl/max6675_responder_sync_edge.sv
// Brings an asynchronous pin into the clk domain and produces single-cycle rise/fall pulses.
// Latency: STAGES clk edges from pin to pulse; the action driven by a pulse lands one edge later.
// RST_VAL sets the assumed idle level, so a pin already away from idle at reset release still makes an edge.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the synchronizer and keep the previous synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= (chain << 1) | STAGES'(din);
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/max6675_responder.sv
// Stands in for a MAX6675 thermocouple converter: conversion timer, result latch and SPI shifter.
// Pin-to-action latency is SYNC_STAGES+1 clk edges; a conversion takes CONV_CYCLES clk cycles.
// Read-only slave with no backpressure: a cs_n fall aborts a running conversion; a cs_n rise ends the frame and starts a new conversion.
module max6675_responder
  import max6675_pkg::*;
#(
  parameter int CONV_CYCLES = 11_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [11:0]                temp_code,
  input  logic                       tc_open,
  max6675_responder_if.slave         spi,
  output logic                       conv_busy,
  output logic                       frame_done
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [FRAME_BITS-1:0] result;
  logic [FRAME_BITS-1:0] shreg;
  logic [4:0]            bit_cnt;
  logic                  so_oe_q;
  logic                  sclk_rise, sclk_fall;
  logic                  cs_rise, cs_fall;

  // The serial clock idles low.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi.sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Chip select resets to "deselected", so cs_n held low through reset still gives a fall edge.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi.cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // Main control: conversion timer, result latch, frame shifter and rising-edge counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CONV;
      cnt        <= CW'(CONV_CYCLES - 1);
      conv_busy  <= 1'b1;
      result     <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      so_oe_q    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if ((state != SHIFT) && cs_fall) begin
        // A cs_n fall beats a conversion that completes in the same cycle.
        state     <= SHIFT;
        conv_busy <= 1'b0;
        shreg     <= result;
        bit_cnt   <= '0;
        so_oe_q   <= 1'b1;
      end else begin
        case (state)
          CONV: begin
            if (cnt == '0) begin
              result    <= pack_frame(temp_code, tc_open);
              conv_busy <= 1'b0;
              state     <= READY;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          READY: begin
            state <= READY;
          end
          SHIFT: begin
            if (cs_rise) begin
              shreg     <= '0;
              so_oe_q   <= 1'b0;
              cnt       <= CW'(CONV_CYCLES - 1);
              conv_busy <= 1'b1;
              state     <= CONV;
            end else begin
              if (sclk_fall) begin
                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
              end
              if (sclk_rise && (bit_cnt != 5'd16)) begin
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd15) begin
                  frame_done <= 1'b1;
                end
              end
            end
          end
          default: state <= CONV;
        endcase
      end
    end
  end

  assign spi.so    = shreg[FRAME_BITS-1];
  assign spi.so_oe = so_oe_q;

endmodule

// File: doc/max6675_responder.md
# max6675_responder

Emulates the MAX6675 thermocouple converter's serial interface as an SPI slave. It drives SO with the standard 16-bit read-only frame built from a supplied 12-bit temperature code and an open-thermocouple flag, and models conversion time and the abort-on-CS behaviour. It sits on the board-facing side of the sensor-read path, standing in for the physical chip during bring-up and self-test of the team's MAX6675 reader logic.

## Interface
- `CONV_CYCLES`, default 11_000_000 — conversion time in `clk` cycles (220 ms at 50 MHz).
- `SYNC_STAGES`, default 2 — flip-flop depth of the input synchronizers on `sclk` and `cs_n`.
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `temp_code`  in  12  temperature in 0.25 °C LSB, unsigned; sampled at conversion completion.
- `tc_open`  in  1  open-thermocouple flag; sampled with `temp_code`.
- `sclk`  in  1  serial clock from the master; asynchronous to `clk`.
- `cs_n`  in  1  chip select, active-low; asynchronous to `clk`.
- `so`  out  1  serial data out, MSB first.
- `so_oe`  out  1  output enable for the SO pad driver (1 while selected).
- `conv_busy`  out  1  a conversion is in progress.
- `frame_done`  out  1  one-cycle pulse on the 16th `sclk` rising edge of a frame.

## Operation
- Frame format: bit 15 = 0 (dummy); bits 14:3 = `temp_code`; bit 2 = `tc_open`; bit 1 = 0 (device ID); bit 0 = 0.
- `sclk` and `cs_n` each pass through a `SYNC_STAGES` synchronizer and an edge detector. All decisions use the synchronized edges only.
- States:
  - CONV (CS high, counting): `conv_busy`=1. The counter decrements each cycle. When it reaches 0, the block latches the frame into `result` and goes to READY.
  - READY (CS high, idle): `conv_busy`=0 and `result` is held.
  - SHIFT (CS low).
- Falling edge of `cs_n` from CONV or READY:
  - Go to SHIFT.
  - An active conversion is aborted and `result` keeps its previous value.
  - `result` loads into the shift register; `so` = bit 15 and `so_oe` = 1.
  - The rising-edge count clears.
- In SHIFT:
  - Each `sclk` falling edge shifts the register left, filling with 0, so `so` presents the next bit.
  - Each `sclk` rising edge increments a 5-bit count that saturates at 16.
  - The count's transition from 15 to 16 pulses `frame_done`.
  - After all 16 bits, further `sclk` edges keep `so` = 0 with no further pulses.
- Rising edge of `cs_n` from SHIFT, at any bit position:
  - `so_oe` = 0 and `so` = 0.
  - The counter reloads to `CONV_CYCLES-1` and the state becomes CONV.
  - A partial frame produces no `frame_done`.
- `sclk` edges while CS is high are ignored.
- Reset values: `so`=0, `so_oe`=0, `frame_done`=0, `result`=16'h0000, shift register = 0, count = 0.
  - After reset the state is CONV with counter = `CONV_CYCLES-1` and `conv_busy`=1.
  - This holds even if `cs_n` is low. With `cs_n` low, the synchronizers reset to 1, so a low `cs_n` produces a falling edge and enters SHIFT normally.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronous). The next `cs_n` falling edge starts a fresh frame.

## Timing
- Pin edge to action: `SYNC_STAGES`+1 `clk` rising edges, i.e. 3 with the default.
- `so` and `so_oe` update in that cycle.
- Requirement: `clk` frequency ≥ 8× `sclk` frequency, and `cs_n` setup to the first `sclk` edge ≥ 4 `clk` periods.
- A conversion completes exactly `CONV_CYCLES` cycles after the synchronized `cs_n` rise (or after reset release); `conv_busy` falls in that cycle.
- Conversion completion and a `cs_n` falling edge in the same cycle: the falling edge wins. The conversion aborts and the frame carries the old `result`.
- `frame_done` is high for exactly 1 `clk` cycle per complete frame.

## Structure
- Package `max6675_pkg`:
  - constant `FRAME_BITS`=16;
  - bit-position constants (`TEMP_MSB`=14, `TEMP_LSB`=3, `OPEN_BIT`=2);
  - state enum {CONV, READY, SHIFT};
  - function `pack_frame(temp_code, tc_open)`.
- Sub-module `sync_edge` (synchronizer plus rise/fall pulse outputs, parameter `STAGES`), instantiated for `sclk` and `cs_n`.

## Test plan
Bench settings: `CONV_CYCLES`=100, `sclk` = `clk`/10, and a model master samples `so` on `sclk` rising edges.
- Reset, keep CS high 120 cycles with `temp_code`=12'h0C8, `tc_open`=0, then read 16 bits → 16'h0640, `so_oe` high only during CS low, one `frame_done`.
- Lower CS 50 cycles after reset → reads 16'h0000, `conv_busy` drops within 3 cycles; after CS high for 100 cycles the next read → 16'h0640.
- `temp_code`=12'hFFF, `tc_open`=1, full conversion → read 16'h7FFC.
- Raise CS after 8 `sclk` clocks → `so_oe`=0 within 3 cycles, no `frame_done`, `conv_busy`=1; a read after 100 cycles → correct full frame.
- 20 `sclk` clocks in one frame → bits 16–19 read 0, exactly one `frame_done`.
- Assert `rst` after 5 bits → `so`/`so_oe`/`frame_done`=0 immediately, `conv_busy`=1 after release; a read after 100 cycles returns the current frame.
